// File: rtl/dvt_printf_pkg.sv
// Shared types and constants for the DVT printf mailbox producer (dvt_printf_tx).
package dvt_printf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_ZERO,
        ST_NOTIFY
    } state_e;

    localparam int LINE_WORDS = 15;
    localparam int LINE_BYTES = 120;

    localparam logic [3:0] LAST_WORD_IDX  = 4'(LINE_WORDS - 1);
    localparam logic [6:0] LINE_BYTES_CNT = 7'(LINE_BYTES);

    localparam logic [7:0] TERM_NUL = 8'h00;
    localparam logic [7:0] TERM_LF  = 8'h0A;
    localparam logic [7:0] TERM_CR  = 8'h0D;

    // Positions on the DVT flag bus, shared with the testbench flag map
    localparam int DVTF_PRINTF_CMD_BIT = 3;
    localparam int DVTF_PAT_W          = 32;

    function automatic logic is_term(input logic [7:0] b);
        return (b == TERM_NUL) || (b == TERM_LF) || (b == TERM_CR);
    endfunction

endpackage

// File: rtl/dvt_printf_tx.sv
// Printf mailbox producer: packs a character line into a 15-word frame and raises DVTF_PRINTF_CMD.
// Optional flag-clear timeout is built in when DVT_PRINTF_TIMEOUT_EN is defined.
module dvt_printf_tx
    import dvt_printf_pkg::*;
#(
    parameter logic [31:0] BUF_BASE    = 32'h0000_1000,
    parameter int unsigned ACK_TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  char_valid,
    output logic                  char_ready,
    input  logic [7:0]            char_data,
    input  logic [1:0]            core_id,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [31:0]           mem_addr,
    output logic [63:0]           mem_wdata,
    output logic [7:0]            mem_mask,
    output logic                  flag_cmd,
    output logic [DVTF_PAT_W-1:0] flag_pat,
    input  logic                  flag_clr,
    output logic                  err_timeout
);

    state_e                  state_q, state_d;
    logic [6:0]              byte_cnt_q, byte_cnt_d;
    logic [3:0]              word_idx_q, word_idx_d;
    logic [63:0]             word_sr_q, word_sr_d;
    logic [1:0]              core_id_q, core_id_d;
    logic                    line_end_q, line_end_d;
    logic                    char_ready_q, char_ready_d;
    logic                    mem_req_q, mem_req_d;
    logic [31:0]             mem_addr_q, mem_addr_d;
    logic [63:0]             mem_wdata_q, mem_wdata_d;
    logic                    flag_cmd_q, flag_cmd_d;
    logic [DVTF_PAT_W-1:0]   flag_pat_q, flag_pat_d;
    logic                    accept;
    logic                    term;

`ifdef DVT_PRINTF_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_timeout_q, err_timeout_d;
`endif

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        word_sr_d  = word_sr_q;
        core_id_d  = core_id_q;
        line_end_d = line_end_q;
        accept     = char_valid && char_ready_q;
        term       = is_term(char_data);
`ifdef DVT_PRINTF_TIMEOUT_EN
        tmo_cnt_d     = '0;
        err_timeout_d = err_timeout_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_FILL: begin
                if (accept) begin
                    if (state_q == ST_IDLE) begin
                        core_id_d  = core_id;
                        word_idx_d = '0;
                        byte_cnt_d = '0;
                        word_sr_d  = '0;
                    end
                    // Byte position within the word is the low 3 bits of the line count
                    word_sr_d[{~byte_cnt_d[2:0], 3'b000} +: 8] = term ? TERM_NUL : char_data;
                    byte_cnt_d = byte_cnt_d + 7'd1;
                    line_end_d = term;
                    if (term || (byte_cnt_d[2:0] == 3'd0)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_gnt) begin
                    word_idx_d = word_idx_q + 4'd1;
                    word_sr_d  = '0;
                    if (word_idx_q == LAST_WORD_IDX) begin
                        state_d = ST_NOTIFY;
                    end else if (line_end_q || (byte_cnt_q == LINE_BYTES_CNT)) begin
                        state_d = ST_ZERO;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_ZERO: begin
                if (mem_gnt) begin
                    word_idx_d = word_idx_q + 4'd1;
                    if (word_idx_q == LAST_WORD_IDX) begin
                        state_d = ST_NOTIFY;
                    end
                end
            end
            ST_NOTIFY: begin
                if (flag_clr) begin
                    state_d = ST_IDLE;
                end
`ifdef DVT_PRINTF_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d       = ST_IDLE;
                    err_timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they change with the state flop
        char_ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
        mem_req_d    = (state_d == ST_WRITE) || (state_d == ST_ZERO);
        mem_addr_d   = mem_req_d ? (BUF_BASE + {25'd0, word_idx_d, 3'd0}) : '0;
        mem_wdata_d  = mem_req_d ? word_sr_d : '0;
        flag_cmd_d   = (state_d == ST_NOTIFY);
        flag_pat_d   = flag_cmd_d ? (BUF_BASE | {30'd0, core_id_d}) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            word_idx_q   <= '0;
            word_sr_q    <= '0;
            core_id_q    <= '0;
            line_end_q   <= 1'b0;
            char_ready_q <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            flag_cmd_q   <= 1'b0;
            flag_pat_q   <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_idx_q   <= word_idx_d;
            word_sr_q    <= word_sr_d;
            core_id_q    <= core_id_d;
            line_end_q   <= line_end_d;
            char_ready_q <= char_ready_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            flag_cmd_q   <= flag_cmd_d;
            flag_pat_q   <= flag_pat_d;
        end
    end

`ifdef DVT_PRINTF_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    // ACK_TIMEOUT only has an effect when the timeout counter is built in
    assign err_timeout = (ACK_TIMEOUT == 0) && 1'b0;
`endif

    assign char_ready = char_ready_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_mask   = 8'hFF;
    assign flag_cmd   = flag_cmd_q;
    assign flag_pat   = flag_pat_q;

endmodule
